// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot loader: takes a length-prefixed little-endian byte
// stream, writes assembled 32-bit words to the imem write port, and holds the
// core in reset until the whole image has been written.
module imem_boot_ctrl #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        error
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StWrite,
    StDone,
    StErr
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     word_idx_q, word_idx_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [15:0]     count_q, count_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [31:0]     word_q, word_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;

  logic            accept;
  logic [15:0]     len_n;

  assign accept = rx_valid && rx_ready;
  assign len_n  = {rx_data, count_q[7:0]};

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      count_q     <= '0;
      tmo_q       <= '0;
      word_q      <= '0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      count_q     <= count_d;
      tmo_q       <= tmo_d;
      word_q      <= word_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    count_d     = count_q;
    tmo_d       = tmo_q;
    word_d      = word_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLen0;
          tmo_d   = '0;
        end
      end
      StLen0: begin
        if (accept) begin
          count_d[7:0] = rx_data;
          state_d      = StLen1;
        end
      end
      StLen1: begin
        if (accept) begin
          count_d[15:8] = rx_data;
          if (len_n == 16'd0 || 32'(len_n) > DEPTH) begin
            state_d = StErr;
          end else begin
            state_d    = StData;
            word_idx_d = '0;
            byte_idx_d = '0;
          end
        end
      end
      StData: begin
        if (accept) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
          if (byte_idx_q == 2'd3) begin
            // Capture the write beat now so the port holds it outside WRITE.
            state_d     = StWrite;
            mem_addr_d  = BASE_ADDR + {14'b0, word_idx_q, 2'b00};
            mem_wdata_d = {rx_data, word_q[23:0]};
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      StWrite: begin
        word_idx_d = word_idx_q + 16'd1;
        byte_idx_d = '0;
        if (word_idx_q + 16'd1 == count_q) begin
          state_d = StDone;
        end else begin
          state_d = StData;
        end
      end
      default: state_d = StIdle;
    endcase

    // Inter-byte idle timeout; a byte on the expiry cycle still wins.
    if (state_q == StLen0 || state_q == StLen1 || state_q == StData) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q == TmoLast) begin
        state_d = StErr;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  // Moore output decode.
  always_comb begin
    rx_ready   = (state_q == StLen0) || (state_q == StLen1) || (state_q == StData);
    mem_we     = (state_q == StWrite);
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
    core_reset = (state_q != StDone);
    done       = (state_q == StDone);
    error      = (state_q == StErr);
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with a write scoreboard.
module tb_imem_boot_ctrl;

  localparam int unsigned DEPTH   = 64;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [31:0] BASE    = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;

  int compared   = 0;
  int mismatched = 0;
  logic [63:0] exp_q[$];
  bit watch_cr = 1'b0;

  imem_boot_ctrl #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every write must match the oldest pending expectation.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      logic [63:0] e;
      chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("write_addr", mem_addr, e[63:32]);
        chk("write_data", mem_wdata, e[31:0]);
      end
      chk("ready_in_write", 32'(rx_ready), 32'd0);
    end
    if (watch_cr) chk("core_reset_reload", 32'(core_reset), 32'd1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bit acc = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = rx_ready;
      tick();
      n++;
    end while (!acc && n < 64);
    if (!acc) chk("byte_accept_timeout", 32'(acc), 32'd1);
    rx_valid = 1'b0;
  endtask

  // Gaps (one idle cycle) go between bytes of a word only.
  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (gap && i < 3) tick();
    end
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  // Called right after the last byte: WRITE now, DONE the following cycle.
  task automatic finish_load(input string tag);
    @(negedge clk);
    chk({tag, "_we"}, 32'(mem_we), 32'd1);
    tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_err_state(input string tag);
    chk({tag, "_error"}, 32'(error), 32'd1);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, "_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Reset state
    tick();
    tick();
    chk("rst_ready", 32'(rx_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_ready", 32'(rx_ready), 32'd0);

    // Single-word load
    pulse_start();
    chk("len0_ready", 32'(rx_ready), 32'd1);
    push_wr(32'h0, 32'h00A0_0513);
    send_len(16'd1);
    send_word(32'h00A0_0513, 1'b0);
    finish_load("n1");

    // Three words with rx_valid toggling
    pulse_start();
    chk("restart_done", 32'(done), 32'd0);
    push_wr(32'h0, 32'h0050_0113);
    push_wr(32'h4, 32'h00C0_0193);
    push_wr(32'h8, 32'hFF71_8393);
    send_byte(8'h03);
    tick();
    send_byte(8'h00);
    tick();
    send_word(32'h0050_0113, 1'b1);
    tick();
    send_word(32'h00C0_0193, 1'b1);
    tick();
    send_word(32'hFF71_8393, 1'b1);
    finish_load("n3");

    // Zero and oversize lengths
    pulse_start();
    send_len(16'd0);
    chk_err_state("len0x0");
    pulse_start();
    chk("err_clear", 32'(error), 32'd0);
    chk("err_restart_ready", 32'(rx_ready), 32'd1);
    send_len(16'd65);
    chk_err_state("len65");
    pulse_start();
    push_wr(32'h0, 32'h1234_5678);
    send_len(16'd1);
    send_word(32'h1234_5678, 1'b0);
    finish_load("after_err");

    // Timeout expiry: 16 idle cycles after byte 2
    pulse_start();
    send_len(16'd1);
    send_byte(8'h13);
    send_byte(8'h05);
    repeat (15) tick();
    chk("tmo_not_yet", 32'(error), 32'd0);
    tick();
    chk_err_state("tmo_expire");

    // Byte on the 16th idle cycle wins
    pulse_start();
    push_wr(32'h0, 32'h00A0_0513);
    send_len(16'd1);
    send_byte(8'h13);
    send_byte(8'h05);
    repeat (15) tick();
    chk("tmo_edge_no_err", 32'(error), 32'd0);
    send_byte(8'hA0);
    send_byte(8'h00);
    finish_load("tmo_edge");

    // Reload from DONE keeps the core in reset throughout
    pulse_start();
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_core_reset", 32'(core_reset), 32'd1);
    watch_cr = 1'b1;
    push_wr(32'h0, 32'hDEAD_BEEF);
    push_wr(32'h4, 32'h0BAD_F00D);
    send_len(16'd2);
    send_word(32'hDEAD_BEEF, 1'b0);
    send_word(32'h0BAD_F00D, 1'b0);
    watch_cr = 1'b0;
    finish_load("reload");

    // Reset mid-DATA after two words abandons the load
    pulse_start();
    push_wr(32'h0, 32'h1111_1111);
    push_wr(32'h4, 32'h2222_2222);
    send_len(16'd3);
    send_word(32'h1111_1111, 1'b0);
    send_word(32'h2222_2222, 1'b0);
    send_byte(8'h33);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_ready", 32'(rx_ready), 32'd0);
    chk("midrst_core_reset", 32'(core_reset), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_error", 32'(error), 32'd0);
    chk("midrst_pending", 32'(exp_q.size()), 32'd0);
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("idle_no_accept", 32'(rx_ready), 32'd0);
    end
    rx_valid = 1'b0;

    // Recovery from IDLE after the aborted load
    pulse_start();
    push_wr(32'h0, 32'hCAFE_0001);
    send_len(16'd1);
    send_word(32'hCAFE_0001, 1'b1);
    finish_load("post_rst");

    tick();
    chk("final_pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
- Boot-load sequencer for the instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word to the instruction memory write port at consecutive word-aligned addresses.
- Holds the core in reset until the program image is fully loaded, then releases it; sits between the host/UART byte receiver, the imem write port and the core reset input.

Parameters:
- DEPTH, 64, instruction memory size in words; the largest legal word count.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word aligned.
- TIMEOUT, 1024, maximum idle cycles allowed between accepted bytes while loading.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE and ERR
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data is valid
- rx_ready  output  1  block accepts a byte this cycle
- mem_we  output  1  imem write enable
- mem_addr  output  32  imem byte address, word aligned
- mem_wdata  output  32  imem write data
- core_reset  output  1  reset to the core; high while not in DONE
- done  output  1  load completed successfully
- error  output  1  load aborted

Behaviour:
- Handshake: a byte transfers on any cycle with rx_valid && rx_ready. The block never depends on rx_valid to drive rx_ready.
- Reset, cycle after reset is sampled high:
  - state=IDLE, word index=0, byte index=0, count=0, timeout counter=0.
  - rx_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, core_reset=1, done=0, error=0.
  - Reset asserted mid-load abandons the load with no further writes.
- Stream format:
  - Bytes 0 and 1 carry word count N, 16-bit little-endian (byte 0 = N[7:0]).
  - The next 4N bytes carry instruction words, each little-endian (first byte = bits [7:0]).
- IDLE: rx_ready=0, core_reset=1. start goes to LEN0.
- LEN0: rx_ready=1. An accepted byte latches N[7:0] and moves to LEN1.
- LEN1: rx_ready=1. An accepted byte latches N[15:8], then:
  - N==0 or N>DEPTH: go to ERR.
  - Otherwise: go to DATA with word index=0 and byte index=0.
- DATA: rx_ready=1. An accepted byte shifts into the word register at lane [byte index].
  - Byte index 3: go to WRITE.
  - Otherwise: increment byte index.
- WRITE: exactly one cycle.
  - rx_ready=0, mem_we=1, mem_addr=BASE_ADDR+4*word index, mem_wdata=assembled word.
  - Next cycle: increment word index and clear byte index. If incremented index==N, go to DONE; else go to DATA.
- DONE: core_reset=0, done=1, rx_ready=0. Stays until start, then goes to LEN0 with done=0 and core_reset=1 in that same next cycle.
- ERR: core_reset=1, error=1, rx_ready=0. start goes to LEN0 and clears error.
- Timeout:
  - The counter clears on entry to LEN0 and on every accepted byte, and increments every other cycle in LEN0, LEN1 and DATA.
  - When the counter reaches TIMEOUT-1 with no byte accepted that cycle, go to ERR.
  - A byte accepted on the same cycle wins and the load continues.
- Output decode: mem_we is high only in WRITE. Outside WRITE, mem_addr and mem_wdata hold their last driven values.
- Other rules:
  - Bytes offered in IDLE, WRITE, DONE and ERR are not accepted.
  - start outside IDLE/DONE/ERR is ignored.
  - Word index is 16 bits wide; address arithmetic wraps modulo 2^32.

Test Plan:
- Reset held 2 cycles, then released → rx_ready=0, mem_we=0, core_reset=1, done=0, error=0, mem_addr=0.
- start; stream 01 00 13 05 A0 00 (N=1, word 0x00A00513) → exactly one write, addr 0x0 data 0x00A00513; next cycle done=1, core_reset=0.
- N=3 with words 0x00500113, 0x00C00193, 0xFF718393, rx_valid toggling every other cycle → writes at 0x0, 0x4, 0x8 in order, rx_ready=0 during each write cycle, done after the third write.
- Length bytes 00 00, and separately 41 00 (N=65 > DEPTH=64) → ERR, error=1, core_reset=1, no write. A following start with a valid stream loads correctly.
- TIMEOUT=16: stall 16 cycles after byte 2 of the first word → ERR, no write. Repeat with the byte arriving on the 16th idle cycle → no error, load completes.
- reset asserted during DATA after 2 words written → IDLE, no further writes. After DONE, start then the 2-word load 02 00 plus two words → rewrites 0x0 and 0x4, core_reset high throughout the reload.
